// File: rtl/text_console.sv
// text_console: character console buffer between the keyboard ASCII path and the
// VGA glyph ROM. Holds a circular COLS x ROWS screen with wrap, newline, backspace
// and hardware scrolling, and serves per-pixel cell lookups with a blinking cursor.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   key_in/key_valid/key_ready ASCII byte input, valid/ready handshake
//   h_addr, v_addr             VGA pixel address
//   ascii_out                  character at the addressed cell (registered)
//   glyph_row, glyph_col       pixel position inside the glyph cell (registered)
//   cursor_hit                 addressed cell is the cursor and blink is on (registered)
//   cursor_x, cursor_y         logical cursor position
module text_console #(
    parameter int unsigned COLS         = 70,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CHAR_W       = 9,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               key_in,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [9:0]               h_addr,
    input  logic [9:0]               v_addr,
    output logic [7:0]               ascii_out,
    output logic [3:0]               glyph_row,
    output logic [3:0]               glyph_col,
    output logic                     cursor_hit,
    output logic [$clog2(COLS)-1:0]  cursor_x,
    output logic [$clog2(ROWS)-1:0]  cursor_y
);
    localparam int unsigned XW    = $clog2(COLS);
    localparam int unsigned YW    = $clog2(ROWS);
    localparam int unsigned Cells = COLS * ROWS;
    localparam int unsigned AW    = $clog2(Cells);
    localparam int unsigned BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   clear_base_q, clear_base_d;
    logic [XW-1:0]   cx_q, cx_d;
    logic [YW-1:0]   cy_q, cy_d;
    logic [YW-1:0]   top_q, top_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;

    logic [7:0]      ascii_q, ascii_d;
    logic [3:0]      grow_q, grow_d;
    logic [3:0]      gcol_q, gcol_d;
    logic            hit_q, hit_d;

    logic [7:0]      mem [Cells];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    logic            newline;
    logic            accept;

    logic [9:0]      cell_x, cell_y;
    logic            in_range;
    logic [AW-1:0]   rd_addr;

    // Logical row + top, wrapped by compare-and-subtract, then flattened to an address.
    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row,
                                                input logic [YW-1:0] top,
                                                input logic [XW-1:0] col);
        logic [YW:0] phys;
        phys = {1'b0, row} + {1'b0, top};
        if (phys >= (YW+1)'(ROWS)) phys = phys - (YW+1)'(ROWS);
        return AW'(phys) * AW'(COLS) + AW'(col);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StInit;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            clear_base_q <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            top_q        <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            ascii_q      <= 8'h00;
            grow_q       <= 4'h0;
            gcol_q       <= 4'h0;
            hit_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            clear_base_q <= clear_base_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            top_q        <= top_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            ascii_q      <= ascii_d;
            grow_q       <= grow_d;
            gcol_q       <= gcol_d;
            hit_q        <= hit_d;
        end
    end

    // Character RAM; a same-cycle read of the written address sees the old byte.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Output logic
    always_comb begin
        key_ready = (state_q == StIdle);
        accept    = key_valid && key_ready;
    end

    // Next-state and write logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_base_d = clear_base_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        top_d        = top_q;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = 8'h00;
        wr_x         = cx_q;
        wr_y         = cy_q;
        newline      = 1'b0;

        unique case (state_q)
            StInit: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == AW'(Cells - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = clear_base_q + cnt_q;
                if (cnt_q == AW'(COLS - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (accept) begin
                    if (key_in >= 8'h20 && key_in <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = key_in;
                        if (cx_q < XW'(COLS - 1)) cx_d = cx_q + 1'b1;
                        else                      newline = 1'b1;
                    end else if (key_in == 8'h0A || key_in == 8'h0D) begin
                        newline = 1'b1;
                    end else if (key_in == 8'h08) begin
                        if (cx_q != '0) begin
                            cx_d    = cx_q - 1'b1;
                            wr_x    = cx_q - 1'b1;
                            wr_en   = 1'b1;
                            wr_data = 8'h20;
                        end else if (cy_q != '0) begin
                            cx_d    = XW'(COLS - 1);
                            cy_d    = cy_q - 1'b1;
                            wr_x    = XW'(COLS - 1);
                            wr_y    = cy_q - 1'b1;
                            wr_en   = 1'b1;
                            wr_data = 8'h20;
                        end
                    end
                    // Character write uses the pre-scroll top.
                    wr_addr = cell_addr(wr_y, top_q, wr_x);
                    if (newline) begin
                        cx_d = '0;
                        if (cy_q < YW'(ROWS - 1)) begin
                            cy_d = cy_q + 1'b1;
                        end else begin
                            top_d        = (top_q == YW'(ROWS - 1)) ? '0 : top_q + 1'b1;
                            clear_base_d = cell_addr('0, top_q, '0);
                            cnt_d        = '0;
                            state_d      = StClear;
                        end
                    end
                end
            end
            default: state_d = StInit;
        endcase

        if (reset) wr_en = 1'b0;
    end

    // Blink phase
    always_comb begin
        blink_on_d = blink_on_q;
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Display lookup
    always_comb begin
        cell_x   = h_addr / 10'(CHAR_W);
        cell_y   = v_addr / 10'(CHAR_H);
        in_range = (cell_x < 10'(COLS)) && (cell_y < 10'(ROWS));
        rd_addr  = in_range ? cell_addr(YW'(cell_y), top_q, XW'(cell_x)) : '0;
        // INIT has not yet cleared the RAM, so blank the screen until it finishes.
        ascii_d  = (in_range && state_q != StInit) ? mem[rd_addr] : 8'h00;
        grow_d   = 4'(v_addr - cell_y * 10'(CHAR_H));
        gcol_d   = 4'(h_addr - cell_x * 10'(CHAR_W));
        hit_d    = in_range && blink_on_q &&
                   (cell_x == 10'(cx_q)) && (cell_y == 10'(cy_q));
    end

    assign ascii_out  = ascii_q;
    assign glyph_row  = grow_q;
    assign glyph_col  = gcol_q;
    assign cursor_hit = hit_q;
    assign cursor_x   = cx_q;
    assign cursor_y   = cy_q;

endmodule

// File: tb/tb_text_console.sv
// tb_text_console: directed self-checking bench for text_console (BLINK_CYCLES=4).
module tb_text_console;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_in = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [9:0] h_addr = 10'd0;
    logic [9:0] v_addr = 10'd0;
    logic [7:0] ascii_out;
    logic [3:0] glyph_row;
    logic [3:0] glyph_col;
    logic       cursor_hit;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    text_console #(.BLINK_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .ascii_out  (ascii_out),
        .glyph_row  (glyph_row),
        .glyph_col  (glyph_col),
        .cursor_hit (cursor_hit),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        key_in    = b;
        key_valid = 1'b1;
        while (!key_ready && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (!key_ready) begin
            errors++;
            $display("FAIL send_timeout: byte %h key_ready=%b required 1", b, key_ready);
        end else begin
            step();
        end
        key_valid = 1'b0;
    endtask

    task automatic read_px(input int h, input int v);
        h_addr = 10'(h);
        v_addr = 10'(v);
        step();
    endtask

    task automatic reset_and_wait();
        int n = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        while (!key_ready && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 2100) begin
            errors++;
            $display("FAIL init_length: got %0d cycles required 2100", n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        int bad = 0;
        h_addr = 10'd13;
        v_addr = 10'd5;
        reset  = 1'b1;
        step();
        step();
        checks++;
        if (key_ready !== 1'b0) begin
            errors++; $display("FAIL reset_key_ready: got %b required 0", key_ready);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
        end
        checks++;
        if (ascii_out !== 8'h00 || glyph_row !== 4'd0 || glyph_col !== 4'd0 || cursor_hit !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_outputs: got ascii=%h row=%0d col=%0d hit=%b required 00 0 0 0",
                     ascii_out, glyph_row, glyph_col, cursor_hit);
        end
        reset  = 1'b0;
        h_addr = 10'd0;
        v_addr = 10'd0;
        while (!key_ready && n < 5000) begin
            if (ascii_out !== 8'h00) bad++;
            step();
            n++;
        end
        checks++;
        if (n !== 2100) begin
            errors++; $display("FAIL init_ready_delay: got %0d cycles required 2100", n);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL init_reads_zero: got %0d nonzero reads required 0", bad);
        end
    endtask

    task automatic test_type_ab();
        send(8'h41);
        send(8'h42);
        checks++;
        if (cursor_x !== 7'd2 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL ab_cursor: got (%0d,%0d) required (2,0)", cursor_x, cursor_y);
        end
        read_px(9, 0);
        checks++;
        if (ascii_out !== 8'h42 || glyph_col !== 4'd0 || glyph_row !== 4'd0) begin
            errors++;
            $display("FAIL ab_px_9_0: got ascii=%h col=%0d row=%0d required 42 0 0",
                     ascii_out, glyph_col, glyph_row);
        end
        read_px(13, 5);
        checks++;
        if (ascii_out !== 8'h42 || glyph_col !== 4'd4 || glyph_row !== 4'd5) begin
            errors++;
            $display("FAIL ab_px_13_5: got ascii=%h col=%0d row=%0d required 42 4 5",
                     ascii_out, glyph_col, glyph_row);
        end
        read_px(0, 0);
        checks++;
        if (ascii_out !== 8'h41) begin
            errors++; $display("FAIL ab_px_0_0: got %h required 41", ascii_out);
        end
    endtask

    task automatic test_wrap();
        reset_and_wait();
        repeat (70) send(8'h78);
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin
            errors++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", cursor_x, cursor_y);
        end
        read_px(621, 0);
        checks++;
        if (ascii_out !== 8'h78) begin
            errors++; $display("FAIL wrap_cell_69_0: got %h required 78", ascii_out);
        end
        send(8'h08);
        checks++;
        if (cursor_x !== 7'd69 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL bs_cursor: got (%0d,%0d) required (69,0)", cursor_x, cursor_y);
        end
        read_px(621, 0);
        checks++;
        if (ascii_out !== 8'h20) begin
            errors++; $display("FAIL bs_cell_69_0: got %h required 20", ascii_out);
        end
        read_px(612, 0);
        checks++;
        if (ascii_out !== 8'h78) begin
            errors++; $display("FAIL bs_cell_68_0: got %h required 78", ascii_out);
        end
    endtask

    task automatic test_scroll();
        int n = 0;
        int bad = 0;
        reset_and_wait();
        repeat (70) send(8'h61);
        send(8'h62);
        repeat (28) send(8'h0A);
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
            errors++; $display("FAIL scroll_pre_cursor: got (%0d,%0d) required (0,29)", cursor_x, cursor_y);
        end
        send(8'h0A);
        while (!key_ready && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (n !== 70) begin
            errors++; $display("FAIL scroll_busy: got %0d cycles required 70", n);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd29) begin
            errors++; $display("FAIL scroll_cursor: got (%0d,%0d) required (0,29)", cursor_x, cursor_y);
        end
        read_px(0, 0);
        checks++;
        if (ascii_out !== 8'h62) begin
            errors++; $display("FAIL scroll_row0_col0: got %h required 62", ascii_out);
        end
        read_px(9, 0);
        checks++;
        if (ascii_out !== 8'h00) begin
            errors++; $display("FAIL scroll_row0_col1: got %h required 00", ascii_out);
        end
        for (int c = 0; c < 70; c++) begin
            read_px(c * 9, 464);
            if (ascii_out !== 8'h00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL scroll_row29_clear: got %0d nonzero cells required 0", bad);
        end
    endtask

    task automatic test_edge();
        reset_and_wait();
        send(8'h08);
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL bs_origin_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
        end
        send(8'h7F);
        send(8'h1B);
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL ignored_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
        end
        read_px(0, 0);
        checks++;
        if (ascii_out !== 8'h00) begin
            errors++; $display("FAIL ignored_cell: got %h required 00", ascii_out);
        end
        send(8'h0A);
        send(8'h51);
        read_px(630, 0);
        checks++;
        if (ascii_out !== 8'h00 || cursor_hit !== 1'b0) begin
            errors++; $display("FAIL px_630: got ascii=%h hit=%b required 00 0", ascii_out, cursor_hit);
        end
        read_px(0, 16);
        checks++;
        if (ascii_out !== 8'h51) begin
            errors++; $display("FAIL px_0_16: got %h required 51", ascii_out);
        end
        read_px(0, 480);
        checks++;
        if (ascii_out !== 8'h00) begin
            errors++; $display("FAIL px_0_480: got %h required 00", ascii_out);
        end
    endtask

    task automatic test_blink();
        logic s [24];
        int   first = -1;
        int   bad = 0;
        logic expv;
        reset_and_wait();
        send(8'h0A);
        send(8'h0A);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        checks++;
        if (cursor_x !== 7'd3 || cursor_y !== 5'd2) begin
            errors++; $display("FAIL blink_cursor: got (%0d,%0d) required (3,2)", cursor_x, cursor_y);
        end
        read_px(27, 32);
        for (int i = 0; i < 24; i++) begin
            s[i] = cursor_hit;
            step();
        end
        for (int i = 1; i < 24; i++) begin
            if (first < 0 && s[i] !== s[i-1]) first = i;
        end
        checks++;
        if (first < 0 || first > 4) begin
            errors++; $display("FAIL blink_first_toggle: got index %0d required 1..4", first);
        end else begin
            for (int j = first; j < 24; j++) begin
                expv = s[first] ^ (((j - first) / 4) % 2 == 1);
                if (s[j] !== expv) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL blink_period: got %0d off-pattern samples required 0", bad);
            end
        end
        bad = 0;
        read_px(36, 32);
        for (int i = 0; i < 8; i++) begin
            if (cursor_hit !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL blink_other_cell: got %0d hits required 0", bad);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        repeat (27) send(8'h0A);
        send(8'h0A);
        checks++;
        if (key_ready !== 1'b0) begin
            errors++; $display("FAIL midclear_busy: got key_ready=%b required 0", key_ready);
        end
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL midclear_reset: got (%0d,%0d) ready=%b required (0,0) 0",
                     cursor_x, cursor_y, key_ready);
        end
        while (!key_ready && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 2100) begin
            errors++; $display("FAIL midclear_init_restart: got %0d cycles required 2100", n);
        end
    endtask

    initial begin
        test_reset();
        test_type_ab();
        test_wrap();
        test_scroll();
        test_edge();
        test_blink();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
